// File: rtl/reloj_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reloj_set_ctrl
//  Purpose  : Time-set sequencer for the HH:MM clock. Debounces the SET and
//             INC buttons, steps RUN -> SET_M0 -> SET_M1 -> SET_H -> RUN on
//             SET presses, issues one-clock increment strobes to the selected
//             digit counter and drives per-digit blink (blank) masks.
//  Ports    : clk         1 MHz master clock, rising edge
//             rst_n       asynchronous reset, active-low
//             tick100_i   one-clock 100 Hz strobe
//             btn_set_i   raw SET button (async, active-high)
//             btn_inc_i   raw INC button (async, active-high)
//             sel_o       mode: 00 RUN, 01 SET_M0, 10 SET_M1, 11 SET_H
//             run_en_o    1 in RUN, 0 in any SET_* mode
//             inc_m0_o / inc_m1_o / inc_h_o        increment strobes
//             blank_m0_o / blank_m1_o / blank_h_o  digit blank masks
//  Options  : `define AUTOREP_EN enables INC auto-repeat while held.
//  Revision : 1.0 - initial release
// ============================================================================
module reloj_set_ctrl #(
    parameter int DEB_TICKS     = 3,
    parameter int BLINK_TICKS   = 25,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int REP_DELAY     = 50,
    parameter int REP_RATE      = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick100_i,
    input  logic       btn_set_i,
    input  logic       btn_inc_i,
    output logic [1:0] sel_o,
    output logic       run_en_o,
    output logic       inc_m0_o,
    output logic       inc_m1_o,
    output logic       inc_h_o,
    output logic       blank_m0_o,
    output logic       blank_m1_o,
    output logic       blank_h_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SET_M0 = 2'b01,
        ST_SET_M1 = 2'b10,
        ST_SET_H  = 2'b11
    } state_t;

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int BL_W = $clog2(BLINK_TICKS + 1);

    // ------------------------------------------------------------------
    // Button conditioning: 2-flop synchroniser, tick-sampled history,
    // stable level and one-clock rise detect. Index 0 = SET, 1 = INC.
    // ------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_rise;

    assign w_btn_raw = {btn_inc_i, btn_set_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic                 sync1_q;
        logic                 sync2_q;
        logic                 stb_q;
        logic                 stbp_q;
        logic [DEB_TICKS-1:0] hist_q;
        logic [DEB_TICKS-1:0] hist_d;

        always_comb begin
            hist_d = (hist_q << 1) | DEB_TICKS'(sync2_q);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                hist_q  <= '0;
                stb_q   <= 1'b0;
                stbp_q  <= 1'b0;
            end else begin
                sync1_q <= w_btn_raw[gi];
                sync2_q <= sync1_q;
                stbp_q  <= stb_q;
                if (tick100_i) begin
                    hist_q <= hist_d;
                    // Level only moves once the whole history agrees.
                    if (&hist_d) begin
                        stb_q <= 1'b1;
                    end else if (~|hist_d) begin
                        stb_q <= 1'b0;
                    end
                end
            end
        end

        assign w_rise[gi] = stb_q & ~stbp_q;
    end

    // ------------------------------------------------------------------
    // Mode sequencer
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [BL_W-1:0]   bc_q, bc_d;
    logic              ph_q, ph_d;
    logic [2:0]        inc_q, inc_d;      // {h, m1, m0}
    logic [2:0]        blank_q, blank_d;  // {h, m1, m0}
    logic              run_en_q, run_en_d;

    logic w_set_ev;
    logic w_inc_ev;
    logic w_in_set;
    logic w_rep_fire;
    logic w_inc_fire;
    logic w_timeout;

    assign w_set_ev   = w_rise[0];
    assign w_inc_ev   = w_rise[1];
    assign w_in_set   = (state_q != ST_RUN);
    // A SET event in the same clock swallows any INC strobe.
    assign w_inc_fire = (w_inc_ev | w_rep_fire) & w_in_set & ~w_set_ev;
    assign w_timeout  = w_in_set & (to_q == TO_W'(TIMEOUT_TICKS));

`ifdef AUTOREP_EN
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RP_W    = $clog2(REP_MAX + 1);

    logic [RP_W-1:0] rc_q;
    logic            first_q;
    logic            w_inc_held;

    assign w_inc_held = g_btn[1].stb_q;
    // First repeat after REP_DELAY ticks, then every REP_RATE ticks.
    assign w_rep_fire = w_inc_held & w_in_set & tick100_i &
                        (first_q ? (rc_q == RP_W'(REP_DELAY - 1))
                                 : (rc_q == RP_W'(REP_RATE - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q    <= '0;
            first_q <= 1'b1;
        end else if (w_inc_ev || (state_d != state_q) || !w_inc_held || !w_in_set) begin
            rc_q    <= '0;
            first_q <= 1'b1;
        end else if (tick100_i) begin
            if (w_rep_fire) begin
                rc_q    <= '0;
                first_q <= 1'b0;
            end else begin
                rc_q    <= rc_q + RP_W'(1);
            end
        end
    end
`else
    // Repeat parameters stay on the interface so both builds are drop-in
    // compatible; the reference folds to a constant zero.
    localparam bit REP_CFG_OK = (REP_DELAY > 0) && (REP_RATE > 0);
    assign w_rep_fire = 1'b0 & REP_CFG_OK;
`endif

    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        bc_d     = bc_q;
        ph_d     = ph_q;
        inc_d    = 3'b000;
        blank_d  = 3'b000;
        run_en_d = (state_q == ST_RUN);

        if (w_set_ev) begin
            state_d = state_t'(state_q + 2'd1);
        end else if (w_timeout && !w_inc_fire) begin
            state_d = ST_RUN;
        end

        if (w_inc_fire) begin
            case (state_q)
                ST_SET_M0: inc_d = 3'b001;
                ST_SET_M1: inc_d = 3'b010;
                ST_SET_H:  inc_d = 3'b100;
                default:   inc_d = 3'b000;
            endcase
        end

        // Idle timer: restarts on any state change or accepted press.
        if ((state_d != state_q) || w_inc_fire) begin
            to_d = '0;
        end else if (w_in_set && tick100_i && (to_q != TO_W'(TIMEOUT_TICKS))) begin
            to_d = to_q + TO_W'(1);
        end

        // Blink phase restarts visible whenever the edited value changes.
        if ((state_d != state_q) || w_inc_fire) begin
            bc_d = '0;
            ph_d = 1'b0;
        end else if (tick100_i) begin
            if (bc_q == BL_W'(BLINK_TICKS - 1)) begin
                bc_d = '0;
                ph_d = ~ph_q;
            end else begin
                bc_d = bc_q + BL_W'(1);
            end
        end

        case (state_d)
            ST_SET_M0: blank_d = {2'b00, ph_d};
            ST_SET_M1: blank_d = {1'b0, ph_d, 1'b0};
            ST_SET_H:  blank_d = {ph_d, 2'b00};
            default:   blank_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            to_q     <= '0;
            bc_q     <= '0;
            ph_q     <= 1'b0;
            inc_q    <= 3'b000;
            blank_q  <= 3'b000;
            run_en_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            to_q     <= to_d;
            bc_q     <= bc_d;
            ph_q     <= ph_d;
            inc_q    <= inc_d;
            blank_q  <= blank_d;
            run_en_q <= run_en_d;
        end
    end

    assign sel_o      = state_q;
    assign run_en_o   = run_en_q;
    assign inc_m0_o   = inc_q[0];
    assign inc_m1_o   = inc_q[1];
    assign inc_h_o    = inc_q[2];
    assign blank_m0_o = blank_q[0];
    assign blank_m1_o = blank_q[1];
    assign blank_h_o  = blank_q[2];

endmodule
`default_nettype wire

// File: tb/tb_reloj_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reloj_set_ctrl
//  Purpose  : Self-checking bench for reloj_set_ctrl. A clock-level
//             behavioural model (run-length debounce, integer mode counter,
//             tick counters) is compared with every DUT output each cycle,
//             plus directed checks on pulse counts and mode changes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reloj_set_ctrl;

    localparam int DEB   = 3;
    localparam int BLINK = 25;
    localparam int TMO   = 1000;
    localparam int RDLY  = 50;
    localparam int RRATE = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       bset  = 1'b0;
    logic       binc  = 1'b0;
    logic [1:0] sel;
    logic       run_en, im0, im1, ih, bm0, bm1, bh;

    always #5 clk = ~clk;

    reloj_set_ctrl #(
        .DEB_TICKS(DEB), .BLINK_TICKS(BLINK), .TIMEOUT_TICKS(TMO),
        .REP_DELAY(RDLY), .REP_RATE(RRATE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick100_i(tick),
        .btn_set_i(bset), .btn_inc_i(binc),
        .sel_o(sel), .run_en_o(run_en),
        .inc_m0_o(im0), .inc_m1_o(im1), .inc_h_o(ih),
        .blank_m0_o(bm0), .blank_m1_o(bm1), .blank_h_o(bh)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int       m_s1[2], m_s2[2], m_last[2], m_rl[2], m_stb[2], m_stbp[2];
    int       m_mode, m_to, m_bc, m_ph, m_run_en, m_rc, m_first;
    logic [2:0] m_inc, m_blank;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_last[i] = 0; m_rl[i] = DEB;
            m_stb[i] = 0; m_stbp[i] = 0;
        end
        m_mode = 0; m_to = 0; m_bc = 0; m_ph = 0; m_run_en = 1;
        m_rc = 0; m_first = 1; m_inc = 3'b000; m_blank = 3'b000;
    endtask

    task automatic model_step(input bit t, input bit bs, input bit bi);
        bit rise_s, rise_i, rep, fire, changed;
        int nm;
        int raw[2];
        raw[0] = bs; raw[1] = bi;
        rise_s = (m_stb[0] == 1) && (m_stbp[0] == 0);
        rise_i = (m_stb[1] == 1) && (m_stbp[1] == 0);
        rep = 1'b0;
`ifdef AUTOREP_EN
        rep = t && (m_stb[1] == 1) && (m_mode != 0) &&
              (m_rc + 1 == (m_first != 0 ? RDLY : RRATE));
`endif
        fire = (rise_i || rep) && (m_mode != 0) && !rise_s;
        nm = m_mode;
        if (rise_s) nm = (m_mode + 1) % 4;
        else if (m_mode != 0 && m_to >= TMO && !fire) nm = 0;
        changed = (nm != m_mode);
        m_inc = 3'b000;
        if (fire) m_inc[m_mode - 1] = 1'b1;
        m_run_en = (m_mode == 0) ? 1 : 0;
        if (changed || fire) m_to = 0;
        else if (m_mode != 0 && t && m_to < TMO) m_to++;
        if (rise_i || changed || m_stb[1] == 0 || m_mode == 0) begin
            m_rc = 0; m_first = 1;
        end else if (t) begin
            if (rep) begin m_rc = 0; m_first = 0; end
            else m_rc++;
        end
        if (changed || fire) begin
            m_bc = 0; m_ph = 0;
        end else if (t) begin
            m_bc++;
            if (m_bc == BLINK) begin m_bc = 0; m_ph = 1 - m_ph; end
        end
        m_blank = 3'b000;
        if (nm != 0 && m_ph != 0) m_blank[nm - 1] = 1'b1;
        m_mode = nm;
        for (int i = 0; i < 2; i++) begin
            m_stbp[i] = m_stb[i];
            if (t) begin
                if (m_s2[i] == m_last[i]) m_rl[i] = (m_rl[i] < DEB) ? m_rl[i] + 1 : DEB;
                else begin m_last[i] = m_s2[i]; m_rl[i] = 1; end
                if (m_rl[i] >= DEB) m_stb[i] = m_last[i];
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step(tick, bset, binc);
    end

    // Per-cycle comparison and pulse bookkeeping, away from the active edge.
    int         c_m0 = 0, c_m1 = 0, c_h = 0, c_sel = 0;
    logic [1:0] sel_prev = 2'b00;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("outputs", {23'd0, sel, run_en, ih, im1, im0, bh, bm1, bm0},
                {23'd0, 2'(m_mode), 1'(m_run_en), m_inc, m_blank});
            if (im0) chk("blank_m0_on_inc", bm0, 0);
            if (im1) chk("blank_m1_on_inc", bm1, 0);
            if (ih)  chk("blank_h_on_inc", bh, 0);
            if (im0) c_m0++;
            if (im1) c_m1++;
            if (ih)  c_h++;
            if (sel !== sel_prev) c_sel++;
            sel_prev = sel;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic press(input bit is_set, input int hold, input int gap);
        if (is_set) bset = 1'b1; else binc = 1'b1;
        tick_n(hold);
        if (is_set) bset = 1'b0; else binc = 1'b0;
        tick_n(gap);
    endtask

    int s0, s1, s2, s3, found;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_run_en", run_en, 1);
        chk("rst_inc", {ih, im1, im0}, 0);
        chk("rst_blank", {bh, bm1, bm0}, 0);
        @(negedge clk); rst_n = 1'b1;
        tick_n(5);

        // Glitchy SET must not advance; a clean press advances exactly once.
        s3 = c_sel;
        repeat (3) begin
            bset = 1'b1; tick_n(1); bset = 1'b0; tick_n(2);
        end
        #1;
        chk("glitch_sel", sel, 0);
        press(1'b1, 10, 5);
        #1;
        chk("clean_sel", sel, 1);
        chk("clean_sel_changes", c_sel - s3, 1);
        chk("clean_run_en", run_en, 0);

        // SET_M1: three INC presses -> three inc_m1 strobes only
        press(1'b1, 5, 5);
        tick_n(30);
        s0 = c_m0; s1 = c_m1; s2 = c_h;
        repeat (3) press(1'b0, 5, 8);
        #1;
        chk("m1_sel", sel, 2);
        chk("m1_pulses", c_m1 - s1, 3);
        chk("m1_no_m0", c_m0 - s0, 0);
        chk("m1_no_h", c_h - s2, 0);

        // Simultaneous SET and INC in SET_M0: SET wins
        press(1'b1, 5, 5);
        press(1'b1, 5, 5);
        #1;
        chk("wrap_to_run", sel, 0);
        press(1'b1, 5, 5);
        s0 = c_m0;
        bset = 1'b1; binc = 1'b1;
        tick_n(6);
        bset = 1'b0; binc = 1'b0;
        tick_n(6);
        #1;
        chk("simul_sel", sel, 2);
        chk("simul_no_m0", c_m0 - s0, 0);

        // Timeout from SET_M0, then a late press restarting the count
        press(1'b1, 5, 5);
        press(1'b1, 5, 5);
        press(1'b1, 5, 5);
        tick_n(975);
        #1;
        chk("to_before", sel, 1);
        tick_n(30);
        #1;
        chk("to_after", sel, 0);
        press(1'b1, 5, 5);
        tick_n(890);
        s0 = c_m0;
        press(1'b0, 5, 5);
        tick_n(900);
        #1;
        chk("to_restart_hold", sel, 1);
        chk("to_restart_inc", c_m0 - s0, 1);
        tick_n(120);
        #1;
        chk("to_restart_exp", sel, 0);

        // INC held 155 ticks in SET_H
        press(1'b1, 5, 5);
        press(1'b1, 5, 5);
        press(1'b1, 5, 5);
        s2 = c_h;
        press(1'b0, 155, 8);
        #1;
`ifdef AUTOREP_EN
        chk("hold_pulses", c_h - s2, 7);
`else
        chk("hold_pulses", c_h - s2, 1);
`endif

        // Asynchronous reset mid SET_H with the hour digits blanked
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            tick_n(1);
            #1;
            if (bh) found = 1;
        end
        chk("h_blank_seen", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_blank_h", bh, 0);
        chk("arst_run_en", run_en, 1);
        @(negedge clk); rst_n = 1'b1;
        s0 = c_m0; s1 = c_m1; s2 = c_h;
        tick_n(20);
        #1;
        chk("post_rst_no_inc", (c_m0 - s0) + (c_m1 - s1) + (c_h - s2), 0);
        chk("post_rst_sel", sel, 0);

        // Randomised button activity against the model
        for (int k = 0; k < 150; k++) begin
            bset = ($urandom_range(0, 3) == 0);
            binc = ($urandom_range(0, 1) == 1);
            tick_n($urandom_range(1, 12));
        end
        bset = 1'b0; binc = 1'b0;
        tick_n(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
